// File: rtl/cache_pkg.sv
// Shared types and constants for the cache responder slice.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP
    } state_t;

    localparam int          DATA_W  = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cache_responder_if.sv
// Processor-side memory bus: read/fetch and write strobes in, read data and hit pulse out.
interface cache_responder_if;
    import cache_pkg::*;

    logic              read_en;
    logic              write_en;
    logic [DATA_W-1:0] address_in;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              hit;
    logic              busy;
    logic [DATA_W-1:0] hit_count;
    logic [DATA_W-1:0] miss_count;

    modport master (
        output read_en, write_en, address_in, data_in,
        input  data_out, hit, busy, hit_count, miss_count
    );

    modport slave (
        input  read_en, write_en, address_in, data_in,
        output data_out, hit, busy, hit_count, miss_count
    );

endinterface

// File: rtl/backing_ram.sv
// Word-wide backing store: synchronous write, asynchronous read, zero at configuration.
module backing_ram
    import cache_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk_100,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Write and fill-read addresses are separate so a write landing on the
    // fill-completion cycle still commits at its own address.
    logic [DATA_W-1:0] mem [1<<AW] = '{default: '0};

    always_ff @(posedge clk_100) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cache_responder.sv
// Direct-mapped, write-through, write-allocate cache of one-word lines in front
// of a backing RAM with a fixed miss latency.
module cache_responder
    import cache_pkg::*;
#(
    parameter int MEM_AW     = 10,
    parameter int INDEX_BITS = 4,
    parameter int MISS_LAT   = 4
) (
    input  logic              clk_100,
    input  logic              rst,
    cache_responder_if.slave  bus
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = MEM_AW - INDEX_BITS;
    localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       fill_cnt;
    logic [MEM_AW-1:0]      fill_addr, req_addr;
    logic [INDEX_BITS-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]       req_tag, fill_tag;
    logic [LINES-1:0]       valid;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [DATA_W-1:0]      line_q [LINES];
    logic [DATA_W-1:0]      data_out_q, hit_cnt_q, miss_cnt_q;
    logic [DATA_W-1:0]      ram_rdata, fill_data;
    logic                   lookup_hit, fill_done;
    logic                   do_hit, do_miss, line_wr;
    logic                   unused_addr_hi;

    assign req_addr       = bus.address_in[MEM_AW-1:0];
    assign unused_addr_hi = ^bus.address_in[DATA_W-1:MEM_AW];
    assign req_idx        = req_addr[INDEX_BITS-1:0];
    assign req_tag        = req_addr[MEM_AW-1:INDEX_BITS];
    assign fill_idx       = fill_addr[INDEX_BITS-1:0];
    assign fill_tag       = fill_addr[MEM_AW-1:INDEX_BITS];

    assign lookup_hit = valid[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill_done  = (state == FILL) && (fill_cnt == '0);
    // A write to the line being filled wins over the stale RAM word.
    assign fill_data  = (bus.write_en && (req_addr == fill_addr)) ? bus.data_in : ram_rdata;

    backing_ram #(.AW(MEM_AW)) u_ram (
        .clk_100 (clk_100),
        .we      (bus.write_en),
        .waddr   (req_addr),
        .wdata   (bus.data_in),
        .raddr   (fill_addr),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        line_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.write_en) begin
                    line_wr = 1'b1;
                end else if (bus.read_en) begin
                    if (lookup_hit) begin
                        do_hit    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        do_miss   = 1'b1;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                line_wr = bus.write_en && lookup_hit;
                if (fill_cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                line_wr   = bus.write_en && lookup_hit;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            fill_cnt   <= '0;
            fill_addr  <= '0;
            data_out_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid      <= '0;
        end else begin
            if (do_miss) begin
                fill_cnt  <= CNT_W'(MISS_LAT - 1);
                fill_addr <= req_addr;
                if (miss_cnt_q != CNT_MAX) miss_cnt_q <= miss_cnt_q + 16'd1;
            end else if ((state == FILL) && (fill_cnt != '0)) begin
                fill_cnt <= fill_cnt - CNT_W'(1);
            end
            if (do_hit) begin
                data_out_q <= line_q[req_idx];
                if (hit_cnt_q != CNT_MAX) hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (line_wr) valid[req_idx] <= 1'b1;
            if (fill_done) begin
                valid[fill_idx] <= 1'b1;
                data_out_q      <= fill_data;
            end
        end
    end

    // Line payloads need no reset; the valid bits guard them. Fill is ordered
    // last so it wins over a same-index write to a different tag.
    always_ff @(posedge clk_100) begin
        if (line_wr) begin
            tag_q[req_idx]  <= req_tag;
            line_q[req_idx] <= bus.data_in;
        end
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            line_q[fill_idx] <= fill_data;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.hit        = (state == RESP);
    assign bus.busy       = (state != IDLE);
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

endmodule
